// File: rtl/post_adder_acc_stage.sv
// DSP48A1-style post-adder/accumulator: X/Z operand select, add/subtract with carry-in, registered P and CARRYOUT.
// Optional sticky signed-overflow output ovf is enabled by defining PADD_OVERFLOW_FLAG_EN.
module post_adder_acc_stage #(
  parameter int CREG       = 1,
  parameter int OPMODEREG  = 1,
  parameter int CARRYINREG = 1,
  parameter int PREG       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cec,
  input  logic        ceopmode,
  input  logic        cecarryin,
  input  logic        cep,
  input  logic [35:0] m_in,
  input  logic [47:0] dab_in,
  input  logic [47:0] c_in,
  input  logic [47:0] pcin,
  input  logic        carryin,
  input  logic [4:0]  opmode,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic        carryout
`ifdef PADD_OVERFLOW_FLAG_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_MULT = 2'd1,
    X_PREG = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_PREG = 2'd2,
    Z_CREG = 2'd3
  } z_sel_e;

  logic [47:0] c_sel;
  logic [4:0]  op_sel;
  logic        cin_sel;
  logic [47:0] p_fb;
  logic [47:0] x_mux;
  logic [47:0] z_mux;
  logic [48:0] sum;
  x_sel_e      x_sel;
  z_sel_e      z_sel;

  // ---------------- C input register ----------------
  if (CREG != 0) begin : g_creg
    logic [47:0] c_q, c_d;
    assign c_d = cec ? c_in : c_q;
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) c_q <= '0;
      else        c_q <= c_d;
    end
    assign c_sel = c_q;
  end else begin : g_cbyp
    assign c_sel = c_in;
  end

  // ---------------- opmode register ----------------
  if (OPMODEREG != 0) begin : g_opreg
    logic [4:0] op_q, op_d;
    assign op_d = ceopmode ? opmode : op_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) op_q <= '0;
      else        op_q <= op_d;
    end
    assign op_sel = op_q;
  end else begin : g_opbyp
    assign op_sel = opmode;
  end

  // ---------------- carry-in register ----------------
  if (CARRYINREG != 0) begin : g_cinreg
    logic cin_q, cin_d;
    assign cin_d = cecarryin ? carryin : cin_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cin_q <= 1'b0;
      else        cin_q <= cin_d;
    end
    assign cin_sel = cin_q;
  end else begin : g_cinbyp
    assign cin_sel = carryin;
  end

  // ---------------- operand selection ----------------
  assign x_sel = x_sel_e'(op_sel[1:0]);
  assign z_sel = z_sel_e'(op_sel[3:2]);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    x_mux = '0;
    case (x_sel)
      X_ZERO:  x_mux = '0;
      X_MULT:  x_mux = {{12{m_in[35]}}, m_in};
      X_PREG:  x_mux = p_fb;
      X_DAB:   x_mux = dab_in;
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (z_sel)
      Z_ZERO:  z_mux = '0;
      Z_PCIN:  z_mux = pcin;
      Z_PREG:  z_mux = p_fb;
      Z_CREG:  z_mux = c_sel;
      default: z_mux = '0;
    endcase
  end

  // 49-bit arithmetic: bit 48 is carry on add and borrow on subtract.
  always_comb begin
    sum = '0;
    if (op_sel[4]) sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin_sel});
    else           sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin_sel};
  end

`ifdef PADD_OVERFLOW_FLAG_EN
  logic x_sign_eff;
  logic ovf_now;
  // Subtraction adds the inverted X, so its effective sign flips.
  assign x_sign_eff = x_mux[47] ^ op_sel[4];
  assign ovf_now    = (z_mux[47] == x_sign_eff) && (sum[47] != z_mux[47]);
`endif

  // ---------------- P / CARRYOUT register ----------------
  if (PREG != 0) begin : g_preg
    logic [47:0] p_q, p_d;
    logic        co_q, co_d;

    always_comb begin
      p_d  = p_q;
      co_d = co_q;
      if (cep) begin
        p_d  = sum[47:0];
        co_d = sum[48];
      end
    end

    // NOTE: the asynchronous reset clears every stage register; there is no storage array left uninitialised.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_q  <= '0;
        co_q <= 1'b0;
      end else begin
        p_q  <= p_d;
        co_q <= co_d;
      end
    end

`ifdef PADD_OVERFLOW_FLAG_EN
    logic ovf_q, ovf_d;
    assign ovf_d = ovf_q | (cep & ovf_now);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif

    assign p_fb     = p_q;
    assign p        = p_q;
    assign carryout = co_q;
  end else begin : g_pbyp
    // Without a P register the feedback path would be a combinational loop, so it reads as zero.
    assign p_fb     = '0;
    assign p        = sum[47:0];
    assign carryout = sum[48];
`ifdef PADD_OVERFLOW_FLAG_EN
    assign ovf      = ovf_now;
`endif
  end

  assign pcout = p;

endmodule

// File: tb/tb_post_adder_acc_stage.sv
// Self-checking bench for post_adder_acc_stage (default parameters): vector table, directed
// multi-cycle sequences and a randomized run against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_post_adder_acc_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cec, ceopmode, cecarryin, cep;
  logic [35:0] m_in;
  logic [47:0] dab_in, c_in, pcin;
  logic        carryin;
  logic [4:0]  opmode;
  logic [47:0] p, pcout;
  logic        carryout;
`ifdef PADD_OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  post_adder_acc_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cec       (cec),
    .ceopmode  (ceopmode),
    .cecarryin (cecarryin),
    .cep       (cep),
    .m_in      (m_in),
    .dab_in    (dab_in),
    .c_in      (c_in),
    .pcin      (pcin),
    .carryin   (carryin),
    .opmode    (opmode),
    .p         (p),
    .pcout     (pcout),
    .carryout  (carryout)
`ifdef PADD_OVERFLOW_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [4:0]  op;
    logic        ci;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pc;
    logic [47:0] exp_p;
    logic        exp_co;
  } vec_t;

  typedef struct {
    logic [4:0]  op;
    logic        ci;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pc;
    logic        ce_p;
  } stim_t;

  localparam longint TWO48 = 64'sh0001_0000_0000_0000;
  localparam longint TWO47 = 64'sh0000_8000_0000_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic ci, input logic [35:0] m,
                       input logic [47:0] dab, input logic [47:0] c, input logic [47:0] pc);
    opmode = op; carryin = ci; m_in = m; dab_in = dab; c_in = c; pcin = pc;
  endtask

  // Called 1 ns after a rising edge; reset pulse finishes well before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Operand values as plain non-negative integers below 2^48.
  function automatic longint operand_x(input logic [1:0] sel, input logic [35:0] m,
                                       input logic [47:0] dab, input longint pfb);
    longint v;
    case (sel)
      2'd1: begin
        v = longint'($signed(m));
        if (v < 0) v = v + TWO48;
      end
      2'd2:    v = pfb;
      2'd3:    v = {16'd0, dab};
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic longint operand_z(input logic [1:0] sel, input logic [47:0] pc,
                                       input logic [47:0] c, input longint pfb);
    longint v;
    case (sel)
      2'd1:    v = {16'd0, pc};
      2'd2:    v = pfb;
      2'd3:    v = {16'd0, c};
      default: v = 0;
    endcase
    return v;
  endfunction

  // Returns {carry/borrow, result[47:0]} from exact integer arithmetic.
  function automatic logic [48:0] ref_calc(input logic [4:0] op, input logic ci, input logic [35:0] m,
                                           input logic [47:0] dab, input logic [47:0] c,
                                           input logic [47:0] pc, input logic [47:0] pfb);
    longint x, z, cil, r;
    logic   co;
    logic [63:0] ru;
    cil = {63'd0, ci};
    x = operand_x(op[1:0], m, dab, {16'd0, pfb});
    z = operand_z(op[3:2], pc, c, {16'd0, pfb});
    if (op[4]) begin
      r  = z - x - cil;
      co = (r < 0);
    end else begin
      r  = z + x + cil;
      co = (r >= TWO48);
    end
    ru = r;
    return {co, ru[47:0]};
  endfunction

  function automatic logic ref_ovf(input logic [4:0] op, input logic ci, input logic [35:0] m,
                                   input logic [47:0] dab, input logic [47:0] c,
                                   input logic [47:0] pc, input logic [47:0] pfb);
    longint x, z, cil, t;
    cil = {63'd0, ci};
    x = operand_x(op[1:0], m, dab, {16'd0, pfb});
    z = operand_z(op[3:2], pc, c, {16'd0, pfb});
    if (x >= TWO47) x = x - TWO48;
    if (z >= TWO47) z = z - TWO48;
    t = op[4] ? (z - x - cil) : (z + x + cil);
    return (t >= TWO47) || (t < -TWO47);
  endfunction

  vec_t  tbl[9];
  stim_t cur, prev;
  logic [47:0] p_m;
  logic        co_m;
  logic        ovf_m;
  logic [48:0] r;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{op:5'b00001, ci:1'b0, m:-36'sd5,        dab:48'd0,  c:48'd0,    pc:48'd0,
               exp_p:48'hFFFF_FFFF_FFFB, exp_co:1'b0};
    tbl[1] = '{op:5'b11111, ci:1'b1, m:36'd0,          dab:48'd30, c:48'd100,  pc:48'd0,
               exp_p:48'd69,             exp_co:1'b0};
    tbl[2] = '{op:5'b11111, ci:1'b1, m:36'd0,          dab:48'd1,  c:48'd0,    pc:48'd0,
               exp_p:48'hFFFF_FFFF_FFFE, exp_co:1'b1};
    tbl[3] = '{op:5'b00111, ci:1'b0, m:36'd0,          dab:48'd1,  c:48'd0,    pc:48'hFFFF_FFFF_FFFF,
               exp_p:48'd0,              exp_co:1'b1};
    tbl[4] = '{op:5'b01101, ci:1'b0, m:-36'sd1000,     dab:48'd0,  c:48'd1000, pc:48'd0,
               exp_p:48'd0,              exp_co:1'b1};
    tbl[5] = '{op:5'b10100, ci:1'b1, m:36'd0,          dab:48'd0,  c:48'd0,    pc:48'd10,
               exp_p:48'd9,              exp_co:1'b0};
    tbl[6] = '{op:5'b10011, ci:1'b0, m:36'd0,          dab:48'd5,  c:48'd0,    pc:48'd0,
               exp_p:48'hFFFF_FFFF_FFFB, exp_co:1'b1};
    tbl[7] = '{op:5'b00000, ci:1'b1, m:36'd0,          dab:48'd0,  c:48'd0,    pc:48'd0,
               exp_p:48'd1,              exp_co:1'b0};
    tbl[8] = '{op:5'b01100, ci:1'b1, m:36'd0,          dab:48'd0,  c:48'h7FFF_FFFF_FFFF, pc:48'd0,
               exp_p:48'h8000_0000_0000, exp_co:1'b0};

    cec = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1; cep = 1'b1;
    drive(5'd0, 1'b0, 36'd0, 48'd0, 48'd0, 48'd0);
    rst_n = 1'b0;
    #12;
    check("reset_p", {16'd0, p}, 64'd0);
    check("reset_co", {63'd0, carryout}, 64'd0);
`ifdef PADD_OVERFLOW_FLAG_EN
    check("reset_ovf", {63'd0, ovf}, 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // Feedback-free vectors: hold for two edges so both pipeline depths settle.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].op, tbl[i].ci, tbl[i].m, tbl[i].dab, tbl[i].c, tbl[i].pc);
      step();
      step();
      check($sformatf("vec%0d_p", i), {16'd0, p}, {16'd0, tbl[i].exp_p});
      check($sformatf("vec%0d_co", i), {63'd0, carryout}, {63'd0, tbl[i].exp_co});
      check($sformatf("vec%0d_pcout", i), {16'd0, pcout}, {16'd0, tbl[i].exp_p});
    end

    // Asynchronous reset clears P before the next clock edge.
    drive(5'b00011, 1'b0, 36'd0, 48'h1234, 48'd0, 48'd0);
    step();
    step();
    check("preload_p", {16'd0, p}, 64'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_p", {16'd0, p}, 64'd0);
    check("async_rst_co", {63'd0, carryout}, 64'd0);
    check("async_rst_pcout", {16'd0, pcout}, 64'd0);
    rst_n = 1'b1;

    // Accumulate m=3 with a one-cycle cep hold, then reset mid-accumulation.
    drive(5'b01001, 1'b0, 36'd3, 48'd0, 48'd0, 48'd0);
    step();
    check("acc_0", {16'd0, p}, 64'd0);
    step();
    check("acc_3", {16'd0, p}, 64'd3);
    step();
    check("acc_6", {16'd0, p}, 64'd6);
    cep = 1'b0;
    step();
    check("acc_hold6", {16'd0, p}, 64'd6);
    cep = 1'b1;
    step();
    check("acc_9", {16'd0, p}, 64'd9);
    step();
    check("acc_12", {16'd0, p}, 64'd12);
    rst_n = 1'b0;
    #1;
    check("acc_rst", {16'd0, p}, 64'd0);
    rst_n = 1'b1;
    step();
    check("acc_restart0", {16'd0, p}, 64'd0);
    step();
    check("acc_restart3", {16'd0, p}, 64'd3);

    // Wrap: all-ones P plus carry-in.
    drive(5'b00011, 1'b0, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0);
    step();
    step();
    drive(5'b01000, 1'b1, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0);
    step();
    check("wrap_pre", {16'd0, p}, 64'hFFFF_FFFF_FFFF);
    step();
    check("wrap_p", {16'd0, p}, 64'd0);
    check("wrap_co", {63'd0, carryout}, 64'd1);
    step();
    check("wrap_next_p", {16'd0, p}, 64'd1);
    check("wrap_next_co", {63'd0, carryout}, 64'd0);

    // X=P and Z=P together: doubles P plus carry-in.
    drive(5'b00011, 1'b0, 36'd0, 48'd5, 48'd0, 48'd0);
    step();
    step();
    drive(5'b01010, 1'b1, 36'd0, 48'd5, 48'd0, 48'd0);
    step();
    step();
    check("double_p", {16'd0, p}, 64'd11);

    // Input register enables hold their captured values.
    drive(5'b01100, 1'b0, 36'd0, 48'd0, 48'd100, 48'd0);
    step();
    step();
    check("en_load_c", {16'd0, p}, 64'd100);
    cec = 1'b0;
    c_in = 48'd7;
    step();
    step();
    check("en_cec_hold", {16'd0, p}, 64'd100);
    ceopmode = 1'b0;
    opmode = 5'b00000;
    step();
    step();
    check("en_ceop_hold", {16'd0, p}, 64'd100);
    cecarryin = 1'b0;
    carryin = 1'b1;
    step();
    step();
    check("en_cecin_hold", {16'd0, p}, 64'd100);
    cecarryin = 1'b1;
    step();
    step();
    check("en_cecin_load", {16'd0, p}, 64'd101);
    cec = 1'b1; ceopmode = 1'b1;

`ifdef PADD_OVERFLOW_FLAG_EN
    do_reset();
    drive(5'b01111, 1'b0, 36'd0, 48'd1, 48'h7FFF_FFFF_FFFF, 48'd0);
    step();
    step();
    check("ovf_p", {16'd0, p}, 64'h8000_0000_0000);
    check("ovf_set", {63'd0, ovf}, 64'd1);
    drive(5'b01111, 1'b0, 36'd0, 48'd0, 48'd0, 48'd0);
    step();
    step();
    check("ovf_zero_p", {16'd0, p}, 64'd0);
    check("ovf_sticky", {63'd0, ovf}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("ovf_cleared", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
`endif

    // Randomized run against the integer reference model.
    step();
    cec = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1; cep = 1'b1;
    do_reset();
    prev  = '{op:5'd0, ci:1'b0, m:36'd0, dab:48'd0, c:48'd0, pc:48'd0, ce_p:1'b1};
    p_m   = '0;
    co_m  = 1'b0;
    ovf_m = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cur.op   = 5'($urandom);
      cur.ci   = 1'($urandom);
      cur.m    = {4'($urandom), 32'($urandom)};
      cur.dab  = {16'($urandom), 32'($urandom)};
      cur.c    = {16'($urandom), 32'($urandom)};
      cur.pc   = ($urandom_range(0, 3) == 0) ? 48'd0 : {16'($urandom), 32'($urandom)};
      cur.ce_p = ($urandom_range(0, 7) != 0);
      drive(cur.op, cur.ci, cur.m, cur.dab, cur.c, cur.pc);
      cep = cur.ce_p;
      step();
      if (cur.ce_p) begin
        r = ref_calc(prev.op, prev.ci, cur.m, cur.dab, prev.c, cur.pc, p_m);
        ovf_m = ovf_m | ref_ovf(prev.op, prev.ci, cur.m, cur.dab, prev.c, cur.pc, p_m);
        p_m  = r[47:0];
        co_m = r[48];
      end
      check($sformatf("rnd%0d_p", i), {16'd0, p}, {16'd0, p_m});
      check($sformatf("rnd%0d_co", i), {63'd0, carryout}, {63'd0, co_m});
      check($sformatf("rnd%0d_pcout", i), {16'd0, pcout}, {16'd0, p_m});
`ifdef PADD_OVERFLOW_FLAG_EN
      check($sformatf("rnd%0d_ovf", i), {63'd0, ovf}, {63'd0, ovf_m});
`endif
      prev = cur;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
